key_debounce: RTL

Front-end conditioning stage for the two board push-buttons. Synchronises the raw active-low key inputs into `sys_clk`, rejects contact bounce by requiring a level to be stable for a programmable number of cycles, and presents clean levels plus single-cycle press/release strobes. Its `keys_clean` output drives the `keys` input of the LED-pattern stage directly; that input keeps the same active-low encoding, so 2'b11 means no key pressed.

---
 rtl/key_debounce.sv | 118 +++++++++++
 1 files changed

// File: rtl/key_debounce.sv
// key_debounce: front-end conditioning for the two board push-buttons.
// Synchronises the raw active-low keys into sys_clk and rejects contact
// bounce with a per-key stability counter and FSM. It then presents clean
// levels plus single-cycle press/release strobes. keys_clean keeps the
// active-low encoding of keys, so 2'b11 means no key pressed.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CNT_W           = 20
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic [1:0] keys,
  output logic [1:0] keys_clean,
  output logic [1:0] key_press,
  output logic [1:0] key_release
);

  typedef enum logic [1:0] {
    ST_RELEASED,
    ST_PRESS_WAIT,
    ST_PRESSED,
    ST_RELEASE_WAIT
  } state_t;

  // Acceptance happens on the edge at which the counter already holds
  // DEBOUNCE_CYCLES-1. Combined with the entry edge, the new level is
  // therefore seen for DEBOUNCE_CYCLES consecutive cycles.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [1:0]       sync1;
  logic [1:0]       sync2;
  state_t           state [2];
  logic [CNT_W-1:0] cnt   [2];

  // Two-flop synchroniser. It resets to the released level so reset never looks like a press.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      sync1 <= 2'b11;
      sync2 <= 2'b11;
    end else begin
      // NOTE: non-blocking, so sync2 takes the previous sync1 and the two flops form a real chain.
      sync1 <= keys;
      sync2 <= sync1;
    end
  end

  // Independent debounce FSM per key, with registered clean level and strobes.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      for (int k = 0; k < 2; k++) begin
        state[k] <= ST_RELEASED;
        cnt[k]   <= '0;
      end
      keys_clean  <= 2'b11;
      key_press   <= 2'b00;
      key_release <= 2'b00;
    end else begin
      // NOTE: strobes default low here. The later per-key assignment in this block wins,
      // so each strobe is high for exactly the one accepting cycle.
      key_press   <= 2'b00;
      key_release <= 2'b00;
      for (int k = 0; k < 2; k++) begin
        case (state[k])
          ST_RELEASED: begin
            if (!sync2[k]) begin
              state[k] <= ST_PRESS_WAIT;
              cnt[k]   <= CNT_ONE;
            end else begin
              cnt[k]   <= '0;
            end
          end
          ST_PRESS_WAIT: begin
            if (sync2[k]) begin
              // Bounce back high: drop the candidate press silently.
              state[k] <= ST_RELEASED;
              cnt[k]   <= '0;
            end else if (cnt[k] == CNT_LAST) begin
              state[k]      <= ST_PRESSED;
              keys_clean[k] <= 1'b0;
              key_press[k]  <= 1'b1;
              cnt[k]        <= '0;
            end else begin
              cnt[k]   <= cnt[k] + CNT_ONE;
            end
          end
          ST_PRESSED: begin
            if (sync2[k]) begin
              state[k] <= ST_RELEASE_WAIT;
              cnt[k]   <= CNT_ONE;
            end else begin
              cnt[k]   <= '0;
            end
          end
          ST_RELEASE_WAIT: begin
            if (!sync2[k]) begin
              // Bounce back low: drop the candidate release silently.
              state[k] <= ST_PRESSED;
              cnt[k]   <= '0;
            end else if (cnt[k] == CNT_LAST) begin
              state[k]       <= ST_RELEASED;
              keys_clean[k]  <= 1'b1;
              key_release[k] <= 1'b1;
              cnt[k]         <= '0;
            end else begin
              cnt[k]   <= cnt[k] + CNT_ONE;
            end
          end
          default: begin
            state[k] <= ST_RELEASED;
            cnt[k]   <= '0;
          end
        endcase
      end
    end
  end

endmodule
